// File: rtl/axis_uart_bridge_tx.sv
// axis_uart_bridge_tx
//   Serializes AXI-Stream words onto a UART TX line (8N1 or 8N2). Each accepted
//   word goes out as N_BYTES frames, TDATA[7:0] first, and each byte goes out LSB first.
//
// State table
//   IDLE_ST  | line high, TREADY asserted, waiting for a word
//   START_ST | start bit (line low) for one bit period
//   DATA_ST  | eight data bits, LSB first, one bit period each
//   STOP_ST  | STOP_BITS bit periods high, then next byte or back to idle
//
// Ports
//   clk           : clock
//   reset         : synchronous, active-high reset
//   S_AXIS_TDATA  : word to transmit (N_BYTES*8 bits)
//   S_AXIS_TVALID : word valid
//   S_AXIS_TREADY : high in idle (combinational from state and reset)
//   UART_TX       : registered serial output, idles high
//   BUSY          : high while a word is being serialized
module axis_uart_bridge_tx #(
  parameter int UART_SPEED = 115200,
  parameter int FREQ_HZ    = 100000000,
  parameter int N_BYTES    = 32,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BYTES*8-1:0] S_AXIS_TDATA,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  output logic                 UART_TX,
  output logic                 BUSY
);

  localparam int DATA_WIDTH = N_BYTES * 8;
  localparam int BIT_CYCLES = FREQ_HZ / UART_SPEED;
  localparam int BYTE_W     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [31:0]       LP_BIT_LAST  = 32'(BIT_CYCLES - 1);
  localparam logic [2:0]        LP_STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [BYTE_W-1:0] LP_BYTE_LAST = BYTE_W'(N_BYTES - 1);

  generate
    if (BIT_CYCLES < 2) begin : g_bad_baud
      $error("axis_uart_bridge_tx: FREQ_HZ/UART_SPEED must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("axis_uart_bridge_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE_ST, START_ST, DATA_ST, STOP_ST} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  r_busy;
  logic [31:0]           r_bit_cnt;
  logic [2:0]            r_bit_idx;   // data bit index in DATA_ST, stop bit index in STOP_ST
  logic [BYTE_W-1:0]     r_byte_idx;
  logic [DATA_WIDTH-1:0] r_shift;

  logic w_handshake;
  logic w_bit_done;
  logic w_last_stop;
  logic w_more_bytes;

  assign S_AXIS_TREADY = (r_state == IDLE_ST) & ~reset;
  assign w_handshake   = S_AXIS_TVALID & S_AXIS_TREADY;
  assign w_bit_done    = (r_bit_cnt == LP_BIT_LAST);
  assign w_last_stop   = (r_bit_idx == LP_STOP_LAST);
  assign w_more_bytes  = (r_byte_idx < LP_BYTE_LAST);
  assign UART_TX       = r_tx;
  assign BUSY          = r_busy;

  // The line value is computed for the *next* state so UART_TX can be a flop
  // and still change on the same edge as the state.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = 1'b1;
    case (r_state)
      IDLE_ST: begin
        if (w_handshake) begin
          w_state_next = START_ST;
          w_tx_next    = 1'b0;
        end
      end
      START_ST: begin
        w_tx_next = 1'b0;
        if (w_bit_done) begin
          w_state_next = DATA_ST;
          w_tx_next    = r_shift[0];
        end
      end
      DATA_ST: begin
        w_tx_next = r_shift[0];
        if (w_bit_done) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP_ST;
            w_tx_next    = 1'b1;
          end else begin
            w_tx_next = r_shift[1];
          end
        end
      end
      STOP_ST: begin
        w_tx_next = 1'b1;
        if (w_bit_done && w_last_stop) begin
          if (w_more_bytes) begin
            w_state_next = START_ST;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = IDLE_ST;
          end
        end
      end
      default: begin
        w_state_next = IDLE_ST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE_ST;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != IDLE_ST);

      if (r_state == IDLE_ST) begin
        r_bit_cnt <= '0;
        if (w_handshake) begin
          r_shift    <= S_AXIS_TDATA;
          r_byte_idx <= '0;
          r_bit_idx  <= '0;
        end
      end else begin
        r_bit_cnt <= w_bit_done ? '0 : r_bit_cnt + 32'd1;
      end

      // After eight shifts the next byte of the word sits in r_shift[7:0].
      if (w_bit_done) begin
        case (r_state)
          START_ST: r_bit_idx <= '0;
          DATA_ST: begin
            r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
          STOP_ST: begin
            if (w_last_stop) begin
              r_bit_idx <= '0;
              if (w_more_bytes) r_byte_idx <= r_byte_idx + BYTE_W'(1);
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
